timing_generator: RTL and testbench

Generates VGA raster timing for the display pipeline: signed horizontal/vertical position counters, sync pulses, display-enable and a frame-based animation time base. Sits directly upstream of the background and sprite stages, which consume `counter_h`, `counter_v` and `cur_time` in the same cycle they are produced. The counters are negative during blanking and zero-based across the visible area.

---
 rtl/vga_pkg.sv | 38 +++
 rtl/timing_axis.sv | 69 ++++++
 rtl/timing_generator.sv | 116 +++++++++++
 tb/tb_timing_generator.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA raster timing constants and helpers.
// The background and sprite stages import this so their counter widths
// match the ones produced by timing_generator.
package vga_pkg;

    // Default 640x480 @ 60 Hz timing, pixel counts per region.
    localparam int H_SIZE_DEF  = 640;
    localparam int H_FRONT_DEF = 16;
    localparam int H_SYNC_DEF  = 96;
    localparam int H_BACK_DEF  = 48;

    localparam int V_SIZE_DEF  = 480;
    localparam int V_FRONT_DEF = 10;
    localparam int V_SYNC_DEF  = 2;
    localparam int V_BACK_DEF  = 33;

    // Length of the whole blanking interval of one axis.
    function automatic int blank_len(input int front, input int sync, input int back);
        return front + sync + back;
    endfunction

    // Visible plus blanking length of one axis.
    function automatic int total_len(input int size, input int front, input int sync,
                                     input int back);
        return size + blank_len(front, sync, back);
    endfunction

    // Signed counter width: one extra bit so -BLANK and SIZE-1 both fit.
    function automatic int axis_width(input int total);
        return $clog2(total) + 1;
    endfunction

    localparam int H_TOTAL_DEF = total_len(H_SIZE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
    localparam int V_TOTAL_DEF = total_len(V_SIZE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);
    localparam int H_WIDTH_DEF = axis_width(H_TOTAL_DEF);
    localparam int V_WIDTH_DEF = axis_width(V_TOTAL_DEF);

endpackage

// File: rtl/timing_axis.sv
// One raster axis: signed position counter running -BLANK .. SIZE-1,
// its sync window and visible flag. Used once for H and once for V.
// Outputs sync and count are registered; wrap and visible_next describe
// the value the counter takes at the coming edge so the parent can
// register flags aligned with the counters.
module timing_axis
    import vga_pkg::*;
#(
    parameter int   SIZE  = H_SIZE_DEF,
    parameter int   FRONT = H_FRONT_DEF,
    parameter int   SYNC  = H_SYNC_DEF,
    parameter int   BACK  = H_BACK_DEF,
    parameter logic POL   = 1'b0,
    localparam int  W     = axis_width(total_len(SIZE, FRONT, SYNC, BACK))
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step,
    output logic signed [W-1:0] count,
    output logic                sync,
    output logic                wrap,
    output logic                visible_next
);

    localparam int BLANK     = blank_len(FRONT, SYNC, BACK);
    localparam int FIRST_I   = -BLANK;
    localparam int LAST_I    = SIZE - 1;
    localparam int SYNC_LO_I = FIRST_I + FRONT;
    localparam int SYNC_HI_I = SYNC_LO_I + SYNC - 1;
    localparam int ONE_I     = 1;

    localparam logic signed [W-1:0] FIRST   = FIRST_I[W-1:0];
    localparam logic signed [W-1:0] LAST    = LAST_I[W-1:0];
    localparam logic signed [W-1:0] SYNC_LO = SYNC_LO_I[W-1:0];
    localparam logic signed [W-1:0] SYNC_HI = SYNC_HI_I[W-1:0];
    localparam logic signed [W-1:0] ONE     = ONE_I[W-1:0];

    logic signed [W-1:0] count_next;
    logic                sync_next;

    // Next position: advance on step, wrap from the last visible pixel
    // back to the start of the front porch; derive the flags from it.
    always_comb begin
        count_next = count;
        wrap       = 1'b0;
        if (step) begin
            if (count == LAST) begin
                count_next = FIRST;
                wrap       = 1'b1;
            end else begin
                count_next = count + ONE;
            end
        end
        sync_next    = ((count_next >= SYNC_LO) && (count_next <= SYNC_HI)) ? POL : ~POL;
        visible_next = ~count_next[W-1];
    end

    // Position and sync registers; reset parks at the front-porch start.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= FIRST;
            sync  <= ~POL;
        end else begin
            count <= count_next;
            sync  <= sync_next;
        end
    end

endmodule

// File: rtl/timing_generator.sv
// VGA raster timing generator: signed H/V position counters, sync pulses,
// display enable, end-of-frame pulse and a frame-rate animation time base.
// Every output is a register so downstream stages see counters, syncs,
// de and cur_time all describing the same pixel in the same cycle.
module timing_generator
    import vga_pkg::*;
#(
    parameter int   HSIZE     = H_SIZE_DEF,
    parameter int   HFRONT    = H_FRONT_DEF,
    parameter int   HSYNC     = H_SYNC_DEF,
    parameter int   HBACK     = H_BACK_DEF,
    parameter int   VSIZE     = V_SIZE_DEF,
    parameter int   VFRONT    = V_FRONT_DEF,
    parameter int   VSYNC     = V_SYNC_DEF,
    parameter int   VBACK     = V_BACK_DEF,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    localparam int  HW        = axis_width(total_len(HSIZE, HFRONT, HSYNC, HBACK)),
    localparam int  VW        = axis_width(total_len(VSIZE, VFRONT, VSYNC, VBACK))
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 time_en,
    input  logic [1:0]           time_div,
    output logic signed [HW-1:0] counter_h,
    output logic signed [VW-1:0] counter_v,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic                 frame_end,
    output logic [7:0]           cur_time
);

    logic       h_wrap;
    logic       v_wrap;
    logic       h_visible_next;
    logic       v_visible_next;
    logic       frame_wrap;
    logic [1:0] div_cnt;
    logic [1:0] div_limit;

    timing_axis #(
        .SIZE  (HSIZE),
        .FRONT (HFRONT),
        .SYNC  (HSYNC),
        .BACK  (HBACK),
        .POL   (HSYNC_POL)
    ) u_h_axis (
        .clk          (clk),
        .reset        (reset),
        .step         (1'b1),
        .count        (counter_h),
        .sync         (hsync),
        .wrap         (h_wrap),
        .visible_next (h_visible_next)
    );

    // The vertical axis advances once per completed line.
    timing_axis #(
        .SIZE  (VSIZE),
        .FRONT (VFRONT),
        .SYNC  (VSYNC),
        .BACK  (VBACK),
        .POL   (VSYNC_POL)
    ) u_v_axis (
        .clk          (clk),
        .reset        (reset),
        .step         (h_wrap),
        .count        (counter_v),
        .sync         (vsync),
        .wrap         (v_wrap),
        .visible_next (v_visible_next)
    );

    // Frame boundary and prescaler limit. The prescaler is only two bits,
    // so time_div=3 saturates at a four-frame period like time_div=2.
    always_comb begin
        frame_wrap = h_wrap & v_wrap;
        div_limit  = 2'd3;
        case (time_div)
            2'd0:    div_limit = 2'd0;
            2'd1:    div_limit = 2'd1;
            default: div_limit = 2'd3;
        endcase
    end

    // Display enable and end-of-frame pulse, aligned with the counters.
    // Reset lands the counters on the frame start without a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            de        <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            de        <= h_visible_next & v_visible_next;
            frame_end <= frame_wrap;
        end
    end

    // Animation time base: step on frame boundaries only, so cur_time
    // changes together with frame_end, inside vertical blanking. A
    // prescaler already beyond a newly lowered limit fires immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt  <= 2'd0;
            cur_time <= 8'd0;
        end else if (frame_wrap && time_en) begin
            if (div_cnt >= div_limit) begin
                div_cnt  <= 2'd0;
                cur_time <= cur_time + 8'd1;
            end else begin
                div_cnt  <= div_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_timing_generator.sv
// Bench for timing_generator. A compact-timing instance carries the long
// runs (frames, time base, reset); a default 640x480 instance is checked
// over its first two lines. The reference model derives every expected
// value from the cycle index since reset.
module tb_timing_generator;

    // Compact timing for the frame-level runs.
    localparam int S_HSIZE  = 4;
    localparam int S_HFRONT = 1;
    localparam int S_HSYNC  = 2;
    localparam int S_HBACK  = 1;
    localparam int S_VSIZE  = 3;
    localparam int S_VFRONT = 1;
    localparam int S_VSYNC  = 1;
    localparam int S_VBACK  = 1;
    localparam int S_HPOL   = 1;
    localparam int S_VPOL   = 0;
    localparam int S_HBLANK = S_HFRONT + S_HSYNC + S_HBACK;
    localparam int S_HTOTAL = S_HSIZE + S_HBLANK;
    localparam int S_VBLANK = S_VFRONT + S_VSYNC + S_VBACK;
    localparam int S_VTOTAL = S_VSIZE + S_VBLANK;
    localparam int S_FRAME  = S_HTOTAL * S_VTOTAL;

    // Default 640x480 timing, written out independently of the package.
    localparam int D_HSIZE  = 640;
    localparam int D_HFRONT = 16;
    localparam int D_HSYNC  = 96;
    localparam int D_HBLANK = 160;
    localparam int D_HTOTAL = 800;
    localparam int D_VFRONT = 10;
    localparam int D_VSYNC  = 2;
    localparam int D_VBLANK = 45;
    localparam int D_VTOTAL = 525;

    logic              clk;
    logic              reset;
    logic              time_en;
    logic [1:0]        time_div;

    logic signed [3:0] s_counter_h;
    logic signed [3:0] s_counter_v;
    logic              s_hsync;
    logic              s_vsync;
    logic              s_de;
    logic              s_frame_end;
    logic [7:0]        s_cur_time;

    logic signed [10:0] d_counter_h;
    logic signed [10:0] d_counter_v;
    logic               d_hsync;
    logic               d_vsync;
    logic               d_de;
    logic               d_frame_end;
    logic [7:0]         d_cur_time;

    int         tests_run;
    int         tests_failed;
    int         t;
    int         m_div;
    int         m_time;
    int         last_fe;
    int         de_count;
    int         prev_time;
    bit         check_default;
    logic [7:0] exp_q[$];

    timing_generator #(
        .HSIZE     (S_HSIZE),
        .HFRONT    (S_HFRONT),
        .HSYNC     (S_HSYNC),
        .HBACK     (S_HBACK),
        .VSIZE     (S_VSIZE),
        .VFRONT    (S_VFRONT),
        .VSYNC     (S_VSYNC),
        .VBACK     (S_VBACK),
        .HSYNC_POL (1'b1),
        .VSYNC_POL (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .time_en   (time_en),
        .time_div  (time_div),
        .counter_h (s_counter_h),
        .counter_v (s_counter_v),
        .hsync     (s_hsync),
        .vsync     (s_vsync),
        .de        (s_de),
        .frame_end (s_frame_end),
        .cur_time  (s_cur_time)
    );

    timing_generator dut_vga (
        .clk       (clk),
        .reset     (reset),
        .time_en   (time_en),
        .time_div  (time_div),
        .counter_h (d_counter_h),
        .counter_v (d_counter_v),
        .hsync     (d_hsync),
        .vsync     (d_vsync),
        .de        (d_de),
        .frame_end (d_frame_end),
        .cur_time  (d_cur_time)
    );

    // Clock and reset block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
        end
    endtask

    // Position along one axis for a given step index since reset.
    function automatic int axis_pos(input int idx, input int total, input int blank);
        return (idx % total) - blank;
    endfunction

    // Sync level: active inside the window that follows the front porch.
    function automatic int sync_level(input int pos, input int blank, input int front,
                                      input int sync, input int pol);
        return (pos >= front - blank && pos < front - blank + sync) ? pol : 1 - pol;
    endfunction

    // One clock: advance the model, then sample both DUTs 1 ns after the edge.
    task automatic step();
        logic       en_s;
        logic [1:0] div_s;
        logic       rst_s;
        int         hp;
        int         vp;
        int         lim;
        int         exp_fe;
        en_s  = time_en;
        div_s = time_div;
        rst_s = reset;
        @(posedge clk);
        #1;
        if (rst_s) begin
            t        = 0;
            m_div    = 0;
            m_time   = 0;
            last_fe  = 0;
            de_count = 0;
            exp_q.delete();
        end else begin
            t++;
            if (t % S_FRAME == 0 && en_s) begin
                lim = (div_s == 2'd0) ? 0 : (div_s == 2'd1) ? 1 : 3;
                if (m_div >= lim) begin
                    m_div  = 0;
                    m_time = (m_time + 1) % 256;
                    exp_q.push_back(m_time[7:0]);
                end else begin
                    m_div++;
                end
            end
        end

        hp     = axis_pos(t, S_HTOTAL, S_HBLANK);
        vp     = axis_pos(t / S_HTOTAL, S_VTOTAL, S_VBLANK);
        exp_fe = (t > 0 && t % S_FRAME == 0) ? 1 : 0;
        check("s_counter_h", int'($signed(s_counter_h)), hp);
        check("s_counter_v", int'($signed(s_counter_v)), vp);
        check("s_hsync", int'(s_hsync), sync_level(hp, S_HBLANK, S_HFRONT, S_HSYNC, S_HPOL));
        check("s_vsync", int'(s_vsync), sync_level(vp, S_VBLANK, S_VFRONT, S_VSYNC, S_VPOL));
        check("s_de", int'(s_de), (hp >= 0 && vp >= 0) ? 1 : 0);
        check("s_frame_end", int'(s_frame_end), exp_fe);
        check("s_cur_time", int'(s_cur_time), m_time);

        // Scoreboard of cur_time changes: order and coincidence with frame_end.
        if (rst_s) begin
            prev_time = int'(s_cur_time);
        end else if (int'(s_cur_time) != prev_time) begin
            if (exp_q.size() == 0) check("time_spurious", int'(s_cur_time), prev_time);
            else check("time_seq", int'(s_cur_time), int'(exp_q.pop_front()));
            check("time_on_fe", int'(s_frame_end), 1);
            prev_time = int'(s_cur_time);
        end

        if (s_de) de_count++;
        if (s_frame_end) begin
            check("frame_period", t - last_fe, S_FRAME);
            check("de_per_frame", de_count, S_HSIZE * S_VSIZE);
            last_fe  = t;
            de_count = 0;
        end

        if (check_default) begin
            hp = axis_pos(t, D_HTOTAL, D_HBLANK);
            vp = axis_pos(t / D_HTOTAL, D_VTOTAL, D_VBLANK);
            check("d_counter_h", int'($signed(d_counter_h)), hp);
            check("d_counter_v", int'($signed(d_counter_v)), vp);
            check("d_hsync", int'(d_hsync), sync_level(hp, D_HBLANK, D_HFRONT, D_HSYNC, 0));
            check("d_vsync", int'(d_vsync), sync_level(vp, D_VBLANK, D_VFRONT, D_VSYNC, 0));
            check("d_de", int'(d_de), (hp >= 0 && hp < D_HSIZE && vp >= 0) ? 1 : 0);
            check("d_frame_end", int'(d_frame_end), 0);
            check("d_cur_time", int'(d_cur_time), 0);
        end
    endtask

    initial begin
        int n;
        tests_run     = 0;
        tests_failed  = 0;
        t             = 0;
        m_div         = 0;
        m_time        = 0;
        last_fe       = 0;
        de_count      = 0;
        prev_time     = 0;
        check_default = 1'b1;
        reset         = 1'b1;
        time_en       = 1'b0;
        time_div      = 2'd0;
        repeat (2) step();

        // Two full default lines plus a bit, time base running every frame.
        reset    = 1'b0;
        time_en  = 1'b1;
        time_div = 2'd0;
        repeat (1700) step();
        check_default = 1'b0;

        // Enough single-frame ticks to wrap cur_time through 255 -> 0.
        repeat (260 * S_FRAME) step();

        // Random enable / divider segments, changes landing mid-frame.
        for (int seg = 0; seg < 60; seg++) begin
            time_en  = ($urandom_range(0, 3) != 0);
            time_div = 2'($urandom_range(0, 2));
            repeat ($urandom_range(10, 150)) step();
        end

        // Hold for two frames with the divider at 4, then resume.
        time_div = 2'd2;
        time_en  = 1'b0;
        repeat (2 * S_FRAME) step();
        time_en  = 1'b1;
        repeat (9 * S_FRAME) step();

        // Reset in the middle of the visible area.
        n = 0;
        while (!(int'($signed(s_counter_h)) == 1 && int'($signed(s_counter_v)) == 1)
               && n < 2 * S_FRAME) begin
            step();
            n++;
        end
        check("rst_mid_reached", int'($signed(s_counter_h)), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_h", int'($signed(s_counter_h)), -S_HBLANK);
        check("rst_mid_v", int'($signed(s_counter_v)), -S_VBLANK);
        check("rst_mid_time", int'(s_cur_time), 0);
        check("rst_mid_fe", int'(s_frame_end), 0);
        repeat (3 * S_FRAME + 5) step();

        check("exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
